matvec_mac_engine: RTL

MATVEC_MAC_ENGINE -- requirements
Module: matvec_mac_engine

---
 rtl/matvec_mac_engine.sv | 117 +++++++++++
 1 files changed

// File: rtl/matvec_mac_engine.sv
// Purpose: unsigned DEPTHxDEPTH matrix times DEPTH vector, one column of MACs per cycle (optional MATVEC_MAC_SAT_EN clamps accumulators).
// Latency: done pulses DEPTH+1 cycles after the cycle that samples the mult_valid rising edge; busy is high for DEPTH cycles.
// Backpressure: none; a start seen while busy or in the done cycle is dropped, and a held mult_valid level never retriggers.
module matvec_mac_engine #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_matrix [0:DEPTH-1][0:DEPTH-1],
    input  logic [DATA_WIDTH-1:0] b_vector [0:DEPTH-1],
    input  logic                  mult_valid,
    output logic [ACC_WIDTH-1:0]  result   [0:DEPTH-1],
    output logic                  busy,
    output logic                  done
);

    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [KW-1:0]         k;
    logic                  mv_q;
    logic                  start;
    logic                  last_col;

    logic [DATA_WIDTH-1:0] a_q      [0:DEPTH-1][0:DEPTH-1];
    logic [DATA_WIDTH-1:0] b_q      [0:DEPTH-1];
    logic [ACC_WIDTH-1:0]  acc      [0:DEPTH-1];
    logic [ACC_WIDTH-1:0]  acc_next [0:DEPTH-1];
    logic [2*DATA_WIDTH-1:0] prod   [0:DEPTH-1];
`ifdef MATVEC_MAC_SAT_EN
    logic [ACC_WIDTH:0]    sum      [0:DEPTH-1];
`endif

    assign start    = mult_valid & ~mv_q;
    assign last_col = (k == KW'(DEPTH - 1));
    assign busy     = (state == MAC);
    assign done     = (state == DONE);

    // Column-k products for every row, added to the running sums (wrap or clamp).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            prod[i] = (2*DATA_WIDTH)'(a_q[i][k]) * (2*DATA_WIDTH)'(b_q[k]);
`ifdef MATVEC_MAC_SAT_EN
            // Extra carry bit detects overflow; once clamped, further adds keep it clamped.
            sum[i]      = {1'b0, acc[i]} + {1'b0, ACC_WIDTH'(prod[i])};
            acc_next[i] = sum[i][ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[i][ACC_WIDTH-1:0];
`else
            acc_next[i] = acc[i] + ACC_WIDTH'(prod[i]);
`endif
        end
    end

    // Control: edge detect on mult_valid, state sequencing and column counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            mv_q  <= 1'b0;
        end else begin
            mv_q <= mult_valid;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= MAC;
                        k     <= '0;
                    end
                end
                MAC: begin
                    if (last_col) begin
                        state <= DONE;
                        k     <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: snapshot operands on start, accumulate in MAC, publish result on the last column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    a_q[i][j] <= '0;
                end
                b_q[i]    <= '0;
                acc[i]    <= '0;
                result[i] <= '0;
            end
        end else if (state == IDLE && start) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    a_q[i][j] <= a_matrix[i][j];
                end
                b_q[i] <= b_vector[i];
                acc[i] <= '0;
            end
        end else if (state == MAC) begin
            for (int i = 0; i < DEPTH; i++) begin
                acc[i] <= acc_next[i];
                if (last_col) begin
                    result[i] <= acc_next[i];
                end
            end
        end
    end

endmodule
